sprite_motion_ctrl: RTL and testbench
=====================================

Name: sprite_motion_ctrl

Overview:
Frame-synchronous motion controller for the player sprite drawn by the VGA block.
- Consumes decoded keyboard events (ASCII plus make/break) and a once-per-frame tick.
- Sequences horizontal walking and a jump/fall/land state machine with gravity.
- Drives the sprite X/Y position and state consumed by the VGA renderer and the debug LEDs.
- Position changes only at frame boundaries, so the sprite never tears mid-frame.

Parameters:
SCR_W, 640, visible screen width in pixels
SPR_W, 32, sprite width in pixels
GROUND_Y, 400, sprite top Y when standing on the ground
STEP, 4, horizontal pixels moved per frame while walking
JUMP_V, 12, initial upward velocity in pixels per frame
GRAVITY, 1, velocity change per frame
MAX_FALL, 12, terminal downward velocity

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_key_valid  in  1  one-cycle pulse; i_key_ascii and i_key_break are valid this cycle
i_key_ascii  in  8  ASCII of the event key
i_key_break  in  1  1 = key release, 0 = key press
i_frame_tick  in  1  one-cycle pulse per frame (start of vertical sync)
o_x_pos  out  10  sprite left X
o_y_pos  out  10  sprite top Y
o_state  out  3  0 IDLE, 1 WALK, 2 JUMP, 3 FALL, 4 LAND
o_update  out  1  one-cycle pulse when new position and state are committed

Behaviour:
Reset (asynchronous, active-low):
- o_x_pos = (SCR_W-SPR_W)/2 = 304; o_y_pos = GROUND_Y = 400.
- o_state = IDLE; o_update = 0.
- Internal vy = 0; all key flags and jump_req = 0.
- Reset asserted mid-jump returns immediately to these values.

Key tracking:
- Key tracking happens on i_key_valid only.
- 'a' (0x61) sets or clears held_left on press/release. 'd' (0x64) does the same for held_right.
- 'w' (0x77) press sets jump_req (edge: auto-repeat presses while already set are harmless). Release has no effect.
- Any other ASCII is ignored.

Frame update:
- Occurs only on i_frame_tick. The tick samples the key flags registered before that cycle. A key event in the same cycle as the tick takes effect at the next tick.
- New o_x_pos, o_y_pos and o_state are registered and visible exactly 1 cycle after the tick.
- o_update pulses high in that same cycle. o_update is 0 at all other times.

Horizontal (every tick, in every state):
- dir = right-only: +STEP; left-only: -STEP; both or neither: 0.
- Clamp x to [0, SCR_W-SPR_W] = [0, 608]. A partial step at an edge lands exactly on the edge.

Vertical FSM (each transition happens at a tick):
- IDLE/WALK:
  - If jump_req: vy = JUMP_V, y = y - JUMP_V, then vy = vy - GRAVITY, go to JUMP.
  - Otherwise go to WALK if dir != 0, else IDLE.
- JUMP:
  - y = y - vy, then vy = vy - GRAVITY.
  - When the updated vy reaches 0, go to FALL.
  - Ceiling: if y - vy < 0, set y = 0, vy = 0, go to FALL.
- FALL:
  - vy = min(vy + GRAVITY, MAX_FALL), then y = y + vy.
  - If y + vy >= GROUND_Y: y = GROUND_Y, vy = 0, go to LAND.
- LAND:
  - Hold for exactly one frame, then go to WALK or IDLE by dir.
  - A pending jump is not taken in LAND; it is taken at the following tick.

jump_req handling:
- Cleared at every tick while in JUMP or FALL. Jumps are not buffered through the air.
- Cleared when consumed in IDLE/WALK.
- Retained through LAND.

Arithmetic:
- Y arithmetic uses 11-bit signed intermediates, so there is no wrap-around.
- vy is a 6-bit unsigned magnitude; direction is implied by state.

Ticks:
- Ticks closer than 2 cycles apart are not supported.
- Without ticks, outputs hold indefinitely.

Test Plan:
- Reset, then 5 ticks with no keys -> x=304, y=400, state 0, o_update pulses 1 cycle after each tick.
- Press 'd', 3 ticks, release 'd', 1 tick -> x=316, state 1 after the third tick, then 0. Press 'a' and 'd' together, 2 ticks -> x unchanged.
- Hold 'd' from x=604, 1 tick -> x=608. Further ticks keep x=608, state WALK.
- Press 'w' from ground, tick -> y=388, state 2. After 12 total ticks -> y=322 (apex), state 3. Fall continues until y=400, state 4 for exactly one frame, then state 0.
- Press 'w' while in FALL -> no second jump after landing. Press 'w' during the LAND frame -> jump starts at the following tick.
- Key press in the same cycle as a tick -> ignored by that tick, applied at the next one. Assert i_rst_n=0 mid-jump -> outputs return to 304/400/IDLE asynchronously.

Source files
------------

// File: rtl/sprite_motion_ctrl.sv
// Frame-synchronous sprite motion controller: keyboard-driven walking plus a
// jump/fall/land state machine with gravity, committed once per frame tick.
module sprite_motion_ctrl #(
    parameter int SCR_W    = 640,
    parameter int SPR_W    = 32,
    parameter int GROUND_Y = 400,
    parameter int STEP     = 4,
    parameter int JUMP_V   = 12,
    parameter int GRAVITY  = 1,
    parameter int MAX_FALL = 12
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_key_valid,
    input  logic [7:0] i_key_ascii,
    input  logic       i_key_break,
    input  logic       i_frame_tick,
    output logic [9:0] o_x_pos,
    output logic [9:0] o_y_pos,
    output logic [2:0] o_state,
    output logic       o_update
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WALK = 3'd1,
        ST_JUMP = 3'd2,
        ST_FALL = 3'd3,
        ST_LAND = 3'd4
    } state_t;

    localparam logic signed [10:0] C_X_MAX    = 11'(SCR_W - SPR_W);
    localparam logic signed [10:0] C_STEP     = 11'(STEP);
    localparam logic signed [10:0] C_GROUND   = 11'(GROUND_Y);
    localparam logic signed [10:0] C_ZERO     = 11'sd0;
    localparam logic [5:0]         C_JUMP_V   = 6'(JUMP_V);
    localparam logic [5:0]         C_GRAVITY  = 6'(GRAVITY);
    localparam logic [5:0]         C_MAX_FALL = 6'(MAX_FALL);
    localparam logic [9:0]         C_X_RESET  = 10'((SCR_W - SPR_W) / 2);
    localparam logic [9:0]         C_Y_RESET  = 10'(GROUND_Y);

    state_t     r_state;
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic [5:0] r_vy;
    logic       r_held_left;
    logic       r_held_right;
    logic       r_jump_req;
    logic       r_update;

    state_t            w_state_next;
    logic [9:0]        w_x_next;
    logic [9:0]        w_y_next;
    logic [5:0]        w_vy_next;
    logic              w_jump_clr;
    logic              w_dir_right;
    logic              w_dir_left;
    state_t            w_ground_state;
    logic signed [10:0] w_x_sum;
    logic signed [10:0] w_y_sum;
    logic [5:0]        w_vy_tmp;

    assign w_dir_right    = r_held_right & ~r_held_left;
    assign w_dir_left     = r_held_left & ~r_held_right;
    assign w_ground_state = (w_dir_right | w_dir_left) ? ST_WALK : ST_IDLE;

    // Horizontal motion applies in every state; result is clamped to the screen.
    always_comb begin
        w_x_sum = $signed({1'b0, r_x});
        if (w_dir_right) begin
            w_x_sum = $signed({1'b0, r_x}) + C_STEP;
        end else if (w_dir_left) begin
            w_x_sum = $signed({1'b0, r_x}) - C_STEP;
        end
        if (w_x_sum < C_ZERO) begin
            w_x_next = 10'd0;
        end else if (w_x_sum > C_X_MAX) begin
            w_x_next = C_X_MAX[9:0];
        end else begin
            w_x_next = w_x_sum[9:0];
        end
    end

    // Vertical next-state logic; vy is a magnitude whose sign is implied by the state.
    always_comb begin
        w_state_next = r_state;
        w_y_next     = r_y;
        w_vy_next    = r_vy;
        w_jump_clr   = 1'b0;
        w_y_sum      = $signed({1'b0, r_y});
        w_vy_tmp     = r_vy;
        case (r_state)
            ST_IDLE, ST_WALK: begin
                if (r_jump_req) begin
                    w_jump_clr   = 1'b1;
                    w_y_sum      = $signed({1'b0, r_y}) - $signed({5'b0, C_JUMP_V});
                    w_y_next     = w_y_sum[9:0];
                    w_vy_next    = C_JUMP_V - C_GRAVITY;
                    w_state_next = ST_JUMP;
                end else begin
                    w_state_next = w_ground_state;
                end
            end
            ST_JUMP: begin
                w_jump_clr = 1'b1;
                w_y_sum    = $signed({1'b0, r_y}) - $signed({5'b0, r_vy});
                if (w_y_sum < C_ZERO) begin
                    w_y_next     = 10'd0;
                    w_vy_next    = 6'd0;
                    w_state_next = ST_FALL;
                end else begin
                    w_y_next  = w_y_sum[9:0];
                    w_vy_next = r_vy - C_GRAVITY;
                    if (w_vy_next == 6'd0) begin
                        w_state_next = ST_FALL;
                    end
                end
            end
            ST_FALL: begin
                w_jump_clr = 1'b1;
                w_vy_tmp   = r_vy + C_GRAVITY;
                if (w_vy_tmp > C_MAX_FALL) begin
                    w_vy_tmp = C_MAX_FALL;
                end
                w_y_sum = $signed({1'b0, r_y}) + $signed({5'b0, w_vy_tmp});
                if (w_y_sum >= C_GROUND) begin
                    w_y_next     = C_GROUND[9:0];
                    w_vy_next    = 6'd0;
                    w_state_next = ST_LAND;
                end else begin
                    w_y_next  = w_y_sum[9:0];
                    w_vy_next = w_vy_tmp;
                end
            end
            ST_LAND: begin
                w_state_next = w_ground_state;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_x      <= C_X_RESET;
            r_y      <= C_Y_RESET;
            r_vy     <= 6'd0;
            r_update <= 1'b0;
        end else begin
            r_update <= i_frame_tick;
            if (i_frame_tick) begin
                r_state <= w_state_next;
                r_x     <= w_x_next;
                r_y     <= w_y_next;
                r_vy    <= w_vy_next;
            end
        end
    end

    // A key event coinciding with a tick is recorded after the tick's clear, so it survives.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_held_left  <= 1'b0;
            r_held_right <= 1'b0;
            r_jump_req   <= 1'b0;
        end else begin
            if (i_frame_tick && w_jump_clr) begin
                r_jump_req <= 1'b0;
            end
            if (i_key_valid) begin
                case (i_key_ascii)
                    8'h61: r_held_left  <= ~i_key_break;
                    8'h64: r_held_right <= ~i_key_break;
                    8'h77: if (!i_key_break) r_jump_req <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign o_x_pos  = r_x;
    assign o_y_pos  = r_y;
    assign o_state  = r_state;
    assign o_update = r_update;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl: walking, edge clamp, full jump arc,
// jump request rules, tick/key coincidence and asynchronous reset mid-jump.
module tb_sprite_motion_ctrl;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_key_valid;
    logic [7:0] i_key_ascii;
    logic       i_key_break;
    logic       i_frame_tick;
    logic [9:0] o_x_pos;
    logic [9:0] o_y_pos;
    logic [2:0] o_state;
    logic       o_update;

    int n_cmp;
    int n_mis;

    // Hand-computed jump arc from the ground: y after ticks 1..24.
    int exp_y [0:23] = '{388, 377, 367, 358, 350, 343, 337, 332, 328, 325, 323, 322,
                         323, 325, 328, 332, 337, 343, 350, 358, 367, 377, 388, 400};

    sprite_motion_ctrl dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_key_valid  (i_key_valid),
        .i_key_ascii  (i_key_ascii),
        .i_key_break  (i_key_break),
        .i_frame_tick (i_frame_tick),
        .o_x_pos      (o_x_pos),
        .o_y_pos      (o_y_pos),
        .o_state      (o_state),
        .o_update     (o_update)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Drivers: inputs change on the falling edge; outputs are read there too.
    task automatic key(input logic [7:0] ascii, input logic brk);
        @(negedge i_clk);
        i_key_valid = 1'b1;
        i_key_ascii = ascii;
        i_key_break = brk;
        @(negedge i_clk);
        i_key_valid = 1'b0;
    endtask

    task automatic tick();
        @(negedge i_clk);
        i_frame_tick = 1'b1;
        @(negedge i_clk);
        i_frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n      = 1'b0;
        i_key_valid  = 1'b0;
        i_key_ascii  = 8'h00;
        i_key_break  = 1'b0;
        i_frame_tick = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        n_cmp++;
        if ({o_x_pos, o_y_pos, o_state, o_update} !== {10'd304, 10'd400, 3'd0, 1'b0}) begin
            $display("FAIL reset: got x=%0d y=%0d st=%0d upd=%0d, want 304/400/0/0",
                     o_x_pos, o_y_pos, o_state, o_update);
            n_mis++;
        end
    endtask

    task automatic test_idle_ticks();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if ({o_x_pos, o_y_pos, o_state, o_update} !== {10'd304, 10'd400, 3'd0, 1'b1}) begin
                $display("FAIL idle_tick%0d: got x=%0d y=%0d st=%0d upd=%0d, want 304/400/0/1",
                         i, o_x_pos, o_y_pos, o_state, o_update);
                n_mis++;
            end
            @(negedge i_clk);
            n_cmp++;
            if (o_update !== 1'b0) begin
                $display("FAIL idle_update_low%0d: got %0d, want 0", i, o_update);
                n_mis++;
            end
        end
    endtask

    task automatic test_walk();
        key(8'h64, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_cmp++;
            if ({o_x_pos, o_state} !== {10'(304 + 4 * i), 3'd1}) begin
                $display("FAIL walk_right%0d: got x=%0d st=%0d, want %0d/1",
                         i, o_x_pos, o_state, 304 + 4 * i);
                n_mis++;
            end
        end
        key(8'h64, 1'b1);
        tick();
        n_cmp++;
        if ({o_x_pos, o_state} !== {10'd316, 3'd0}) begin
            $display("FAIL walk_release: got x=%0d st=%0d, want 316/0", o_x_pos, o_state);
            n_mis++;
        end
        key(8'h61, 1'b0);
        key(8'h64, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({o_x_pos, o_state} !== {10'd316, 3'd0}) begin
                $display("FAIL walk_both%0d: got x=%0d st=%0d, want 316/0", i, o_x_pos, o_state);
                n_mis++;
            end
        end
        key(8'h61, 1'b1);
        key(8'h64, 1'b1);
    endtask

    task automatic test_right_edge();
        key(8'h64, 1'b0);
        repeat (72) tick();
        n_cmp++;
        if ({o_x_pos, o_state} !== {10'd604, 3'd1}) begin
            $display("FAIL edge_pre: got x=%0d st=%0d, want 604/1", o_x_pos, o_state);
            n_mis++;
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({o_x_pos, o_state} !== {10'd608, 3'd1}) begin
                $display("FAIL edge_clamp%0d: got x=%0d st=%0d, want 608/1", i, o_x_pos, o_state);
                n_mis++;
            end
        end
        key(8'h64, 1'b1);
        tick();
        n_cmp++;
        if ({o_x_pos, o_state} !== {10'd608, 3'd0}) begin
            $display("FAIL edge_release: got x=%0d st=%0d, want 608/0", o_x_pos, o_state);
            n_mis++;
        end
    endtask

    task automatic test_jump();
        logic [2:0] st;
        key(8'h77, 1'b0);
        key(8'h77, 1'b1);
        for (int i = 0; i < 24; i++) begin
            tick();
            st = (i < 11) ? 3'd2 : ((i < 23) ? 3'd3 : 3'd4);
            n_cmp++;
            if ({o_x_pos, o_y_pos, o_state} !== {10'd608, 10'(exp_y[i]), st}) begin
                $display("FAIL jump_tick%0d: got x=%0d y=%0d st=%0d, want 608/%0d/%0d",
                         i + 1, o_x_pos, o_y_pos, o_state, exp_y[i], st);
                n_mis++;
            end
        end
        tick();
        n_cmp++;
        if ({o_y_pos, o_state} !== {10'd400, 3'd0}) begin
            $display("FAIL jump_after_land: got y=%0d st=%0d, want 400/0", o_y_pos, o_state);
            n_mis++;
        end
    endtask

    task automatic test_no_buffer();
        key(8'h77, 1'b0);
        repeat (12) tick();
        n_cmp++;
        if ({o_y_pos, o_state} !== {10'd322, 3'd3}) begin
            $display("FAIL nobuf_apex: got y=%0d st=%0d, want 322/3", o_y_pos, o_state);
            n_mis++;
        end
        key(8'h77, 1'b0);
        repeat (12) tick();
        n_cmp++;
        if ({o_y_pos, o_state} !== {10'd400, 3'd4}) begin
            $display("FAIL nobuf_land: got y=%0d st=%0d, want 400/4", o_y_pos, o_state);
            n_mis++;
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({o_y_pos, o_state} !== {10'd400, 3'd0}) begin
                $display("FAIL nobuf_idle%0d: got y=%0d st=%0d, want 400/0", i, o_y_pos, o_state);
                n_mis++;
            end
        end
    endtask

    task automatic test_land_jump();
        key(8'h77, 1'b0);
        repeat (24) tick();
        n_cmp++;
        if ({o_y_pos, o_state} !== {10'd400, 3'd4}) begin
            $display("FAIL landjump_land: got y=%0d st=%0d, want 400/4", o_y_pos, o_state);
            n_mis++;
        end
        key(8'h77, 1'b0);
        tick();
        n_cmp++;
        if ({o_y_pos, o_state} !== {10'd400, 3'd0}) begin
            $display("FAIL landjump_hold: got y=%0d st=%0d, want 400/0", o_y_pos, o_state);
            n_mis++;
        end
        tick();
        n_cmp++;
        if ({o_y_pos, o_state} !== {10'd388, 3'd2}) begin
            $display("FAIL landjump_start: got y=%0d st=%0d, want 388/2", o_y_pos, o_state);
            n_mis++;
        end
        repeat (23) tick();
        n_cmp++;
        if ({o_y_pos, o_state} !== {10'd400, 3'd4}) begin
            $display("FAIL landjump_reland: got y=%0d st=%0d, want 400/4", o_y_pos, o_state);
            n_mis++;
        end
        tick();
    endtask

    task automatic test_same_cycle();
        @(negedge i_clk);
        i_frame_tick = 1'b1;
        i_key_valid  = 1'b1;
        i_key_ascii  = 8'h61;
        i_key_break  = 1'b0;
        @(negedge i_clk);
        i_frame_tick = 1'b0;
        i_key_valid  = 1'b0;
        n_cmp++;
        if ({o_x_pos, o_state, o_update} !== {10'd608, 3'd0, 1'b1}) begin
            $display("FAIL same_cycle_tick: got x=%0d st=%0d upd=%0d, want 608/0/1",
                     o_x_pos, o_state, o_update);
            n_mis++;
        end
        tick();
        n_cmp++;
        if ({o_x_pos, o_state} !== {10'd604, 3'd1}) begin
            $display("FAIL same_cycle_next: got x=%0d st=%0d, want 604/1", o_x_pos, o_state);
            n_mis++;
        end
        key(8'h61, 1'b1);
    endtask

    task automatic test_reset_mid_jump();
        key(8'h64, 1'b0);
        key(8'h77, 1'b0);
        repeat (5) tick();
        n_cmp++;
        if ({o_y_pos, o_state} !== {10'd350, 3'd2}) begin
            $display("FAIL midjump_pre: got y=%0d st=%0d, want 350/2", o_y_pos, o_state);
            n_mis++;
        end
        @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({o_x_pos, o_y_pos, o_state, o_update} !== {10'd304, 10'd400, 3'd0, 1'b0}) begin
            $display("FAIL midjump_async_reset: got x=%0d y=%0d st=%0d upd=%0d, want 304/400/0/0",
                     o_x_pos, o_y_pos, o_state, o_update);
            n_mis++;
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();
        n_cmp++;
        if ({o_x_pos, o_y_pos, o_state} !== {10'd304, 10'd400, 3'd0}) begin
            $display("FAIL midjump_flags_cleared: got x=%0d y=%0d st=%0d, want 304/400/0",
                     o_x_pos, o_y_pos, o_state);
            n_mis++;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        test_reset();
        test_idle_ticks();
        test_walk();
        test_right_edge();
        test_jump();
        test_no_buffer();
        test_land_jump();
        test_same_cycle();
        test_reset_mid_jump();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
